hazard_stall_ctrl: RTL and testbench

- Pipeline hazard and stall sequencer for the 5-stage MIPS datapath; sits beside ControlUnit.
- Inputs: IF/ID and ID/EX register fields, EX branch resolution, data-memory ready handshake.
- Drives PC/pipeline-register write enables, bubble and flush controls.
- Tracks multi-cycle memory waits with a timeout and keeps saturating stall/flush performance counters.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/sat_counter.sv | 19 +
 rtl/hazard_stall_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings and field widths for the MIPS pipeline control blocks.
package pipe_pkg;

   localparam int unsigned REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ABORT    = 2'd2
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (clear) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use stalls, branch
// flushes, multi-cycle memory waits with timeout, and perf counters.
module hazard_stall_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] ifIdRs,
   input  logic [REG_W-1:0] ifIdRt,
   input  logic             ifIdUsesRt,
   input  logic             idExMemRead,
   input  logic [REG_W-1:0] idExRt,
   input  logic             exBranchTaken,
   input  logic             exMemAccess,
   input  logic             memReady,
   output logic             pcWrite,
   output logic             ifIdWrite,
   output logic             ifIdFlush,
   output logic             idExBubble,
   output logic             pipeFreeze,
   output logic             memError,
   output logic [CNT_W-1:0] stallCount,
   output logic [CNT_W-1:0] flushCount
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

   state_t            state;
   state_t            state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_cnt_nxt;
   logic              err_nxt;
   logic              stall_inc;
   logic              flush_inc;
   logic              load_use;
   logic              mem_stall;

   // $0 is hard-wired, so a load targeting it can never feed a consumer.
   assign load_use = idExMemRead && (idExRt != REG_ZERO) &&
                     ((idExRt == ifIdRs) || (ifIdUsesRt && (idExRt == ifIdRt)));
   assign mem_stall = exMemAccess && !memReady;

   // Next-state and control decode.
   always_comb begin
      pcWrite      = 1'b1;
      ifIdWrite    = 1'b1;
      ifIdFlush    = 1'b0;
      idExBubble   = 1'b0;
      pipeFreeze   = 1'b0;
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      err_nxt      = memError;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;

      case (state)
         ST_RUN: begin
            if (mem_stall) begin
               pcWrite      = 1'b0;
               ifIdWrite    = 1'b0;
               pipeFreeze   = 1'b1;
               state_nxt    = ST_MEM_WAIT;
               wait_cnt_nxt = WAIT_W'(1);
               stall_inc    = 1'b1;
            end else if (exBranchTaken) begin
               // The ID instruction is squashed, so any load-use there is moot.
               ifIdFlush  = 1'b1;
               idExBubble = 1'b1;
               flush_inc  = 1'b1;
            end else if (load_use) begin
               pcWrite    = 1'b0;
               ifIdWrite  = 1'b0;
               idExBubble = 1'b1;
               stall_inc  = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            pcWrite      = 1'b0;
            ifIdWrite    = 1'b0;
            pipeFreeze   = 1'b1;
            stall_inc    = 1'b1;
            wait_cnt_nxt = wait_cnt + WAIT_W'(1);
            if (memReady) begin
               state_nxt = ST_RUN;
            end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
               err_nxt   = 1'b1;
               state_nxt = ST_ABORT;
            end
         end
         ST_ABORT: begin
            pcWrite    = 1'b0;
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
            state_nxt  = ST_RUN;
         end
         default: begin
            state_nxt = ST_RUN;
         end
      endcase

      if (reset) begin
         pcWrite    = 1'b0;
         ifIdWrite  = 1'b0;
         ifIdFlush  = 1'b1;
         idExBubble = 1'b1;
         pipeFreeze = 1'b0;
         stall_inc  = 1'b0;
         flush_inc  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_RUN;
         wait_cnt <= '0;
         memError <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         memError <= err_nxt;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clear (reset),
      .inc   (stall_inc),
      .cnt   (stallCount)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .clear (reset),
      .inc   (flush_inc),
      .cnt   (flushCount)
   );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector scoreboard bench for hazard_stall_ctrl (MEM_TIMEOUT=8, CNT_W=4).
module tb_hazard_stall_ctrl;

   logic       clk;
   logic       reset;
   logic [4:0] ifIdRs;
   logic [4:0] ifIdRt;
   logic       ifIdUsesRt;
   logic       idExMemRead;
   logic [4:0] idExRt;
   logic       exBranchTaken;
   logic       exMemAccess;
   logic       memReady;
   logic       pcWrite;
   logic       ifIdWrite;
   logic       ifIdFlush;
   logic       idExBubble;
   logic       pipeFreeze;
   logic       memError;
   logic [3:0] stallCount;
   logic [3:0] flushCount;

   hazard_stall_ctrl #(.MEM_TIMEOUT(8), .CNT_W(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .ifIdRs        (ifIdRs),
      .ifIdRt        (ifIdRt),
      .ifIdUsesRt    (ifIdUsesRt),
      .idExMemRead   (idExMemRead),
      .idExRt        (idExRt),
      .exBranchTaken (exBranchTaken),
      .exMemAccess   (exMemAccess),
      .memReady      (memReady),
      .pcWrite       (pcWrite),
      .ifIdWrite     (ifIdWrite),
      .ifIdFlush     (ifIdFlush),
      .idExBubble    (idExBubble),
      .pipeFreeze    (pipeFreeze),
      .memError      (memError),
      .stallCount    (stallCount),
      .flushCount    (flushCount)
   );

   // Control patterns {pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeFreeze}
   localparam logic [4:0] O_RUN = 5'b11000;
   localparam logic [4:0] O_LU  = 5'b00010;
   localparam logic [4:0] O_BR  = 5'b11110;
   localparam logic [4:0] O_FRZ = 5'b00001;
   localparam logic [4:0] O_ABT = 5'b01110;
   localparam logic [4:0] O_RST = 5'b00110;

   typedef struct packed {
      logic [4:0] ctl;
      logic       err;
      logic [3:0] stall;
      logic [3:0] flush;
   } exp_t;

   exp_t  sb_exp[$];
   string sb_name[$];
   int    n_total = 0;
   int    n_pass  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every cycle the DUT presents a response, check it against the queue head.
   always @(negedge clk) begin
      if (sb_exp.size() > 0) begin
         exp_t  e;
         exp_t  a;
         string nm;
         e  = sb_exp.pop_front();
         nm = sb_name.pop_front();
         a  = {pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeFreeze,
               memError, stallCount, flushCount};
         n_total++;
         if (a === e) n_pass++;
         else $display("FAIL %s: got ctl=%b err=%b stall=%0d flush=%0d, want ctl=%b err=%b stall=%0d flush=%0d",
                       nm, a.ctl, a.err, a.stall, a.flush, e.ctl, e.err, e.stall, e.flush);
      end
   end

   task automatic step(input string nm, input bit rst,
                       input bit [4:0] rs, input bit [4:0] rt, input bit ur,
                       input bit mr, input bit [4:0] ert,
                       input bit br, input bit ma, input bit rdy,
                       input logic [4:0] ctl, input bit err, input int s, input int f);
      exp_t e;
      @(posedge clk);
      #1;
      reset         = rst;
      ifIdRs        = rs;
      ifIdRt        = rt;
      ifIdUsesRt    = ur;
      idExMemRead   = mr;
      idExRt        = ert;
      exBranchTaken = br;
      exMemAccess   = ma;
      memReady      = rdy;
      e.ctl   = ctl;
      e.err   = err;
      e.stall = 4'(s);
      e.flush = 4'(f);
      sb_exp.push_back(e);
      sb_name.push_back(nm);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; ifIdRs = '0; ifIdRt = '0; ifIdUsesRt = 1'b0; idExMemRead = 1'b0;
      idExRt = '0; exBranchTaken = 1'b0; exMemAccess = 1'b0; memReady = 1'b0;

      //    name          rst rs     rt     ur mr ert    br ma rdy ctl    err s  f
      step("reset",       1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, O_RST, 0, 0, 0);
      step("run_idle",    0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, O_RUN, 0, 0, 0);
      step("lu_rs",       0, 5'd2, 5'd0, 1, 1, 5'd2, 0, 0, 0, O_LU,  0, 0, 0);
      step("lu_released", 0, 5'd2, 5'd0, 1, 0, 5'd2, 0, 0, 0, O_RUN, 0, 1, 0);
      step("lu_reg0",     0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0, O_RUN, 0, 1, 0);
      step("rt_not_used", 0, 5'd5, 5'd3, 0, 1, 5'd3, 0, 0, 0, O_RUN, 0, 1, 0);
      step("lu_rt_used",  0, 5'd5, 5'd3, 1, 1, 5'd3, 0, 0, 0, O_LU,  0, 1, 0);
      step("branch_lu",   0, 5'd2, 5'd0, 1, 1, 5'd2, 1, 0, 0, O_BR,  0, 2, 0);
      step("after_br",    0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, O_RUN, 0, 2, 1);
      step("mw_enter",    0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, O_FRZ, 0, 2, 1);
      step("mw_1",        0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, O_FRZ, 0, 3, 1);
      step("mw_2",        0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, O_FRZ, 0, 4, 1);
      step("mw_ready",    0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, O_FRZ, 0, 5, 1);
      step("mw_done",     0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, O_RUN, 0, 6, 1);
      step("zero_lat",    0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, O_RUN, 0, 6, 1);
      step("mwb_enter",   0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0, O_FRZ, 0, 6, 1);
      step("mwb_ready",   0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 1, O_FRZ, 0, 7, 1);
      step("mwb_branch",  0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, O_BR,  0, 8, 1);
      step("idle2",       0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, O_RUN, 0, 8, 2);
      step("reset2",      1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, O_RST, 0, 8, 2);
      step("reset2_done", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, O_RUN, 0, 0, 0);
      // memReady held low: 8 frozen cycles, then one abort cycle.
      for (int i = 0; i < 8; i++)
         step("to_wait",  0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, O_FRZ, 0, i, 0);
      step("to_abort",    0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, O_ABT, 1, 8, 0);
      step("post_abort",  0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, O_RUN, 1, 8, 0);
      step("err_sticky",  0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, O_RUN, 1, 8, 0);
      step("rmw_enter",   0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, O_FRZ, 1, 8, 0);
      step("rmw_wait",    0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, O_FRZ, 1, 9, 0);
      step("rmw_reset",   1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, O_RST, 1, 10, 0);
      step("rmw_cleared", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, O_RUN, 0, 0, 0);
      // Continuous load-use stalls drive stallCount into saturation.
      for (int i = 0; i < 20; i++)
         step("sat_stall", 0, 5'd7, 5'd0, 0, 1, 5'd7, 0, 0, 0, O_LU, 0, (i > 15) ? 15 : i, 0);
      step("sat_hold",    0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, O_RUN, 0, 15, 0);

      repeat (2) @(posedge clk);
      n_total++;
      if (sb_exp.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending responses, want 0", sb_exp.size());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
